// File: rtl/yc_noc_pkg.sv
// Shared types for the mesh router: flit types, port indices, flit struct and XY routing.
package yc_noc_pkg;

  localparam int N_PORTS = 5;
  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_TAIL     = 2'b01,
    FT_HEAD     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  localparam int FLIT_DATA_W = 32;

  typedef struct packed {
    flit_type_e             ftype;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

  typedef enum logic {
    S_IDLE,
    S_ROUTED
  } state_e;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [N_PORTS-1:0] xy_route(input logic [31:0] dst_x, input logic [31:0] dst_y,
                                                  input logic [31:0] my_x, input logic [31:0] my_y);
    logic [N_PORTS-1:0] oh;
    oh = '0;
    if (dst_x > my_x)      oh[P_EAST]  = 1'b1;
    else if (dst_x < my_x) oh[P_WEST]  = 1'b1;
    else if (dst_y > my_y) oh[P_NORTH] = 1'b1;
    else if (dst_y < my_y) oh[P_SOUTH] = 1'b1;
    else                   oh[P_LOCAL] = 1'b1;
    return oh;
  endfunction

  function automatic logic is_head(input flit_type_e t);
    return t[1];
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return t[0];
  endfunction

endpackage

// File: rtl/yc_noc_fifo.sv
// Synchronous flit FIFO with a combinational head view; pointers carry one extra wrap bit.
module yc_noc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/yc_noc_inport.sv
// Router input port: flit buffer, XY route of head flits, wormhole-held request, orphan drop.
// Optional forwarded-flit counter enabled by defining YC_NOC_INPORT_STATS_EN.
module yc_noc_inport
  import yc_noc_pkg::*;
#(
  parameter int N       = 5,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W+1:0] in_flit,
  output logic [N-1:0]      req,
  input  logic [N-1:0]      gnt,
  output logic [DATA_W+1:0] out_flit,
  output logic              err,
  output logic [31:0]       flit_cnt
);

  localparam int FW = DATA_W + 2;

  logic [FW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  state_e        state_q;
  state_e        state_next;
  logic [N-1:0]  route_q;
  logic [N-1:0]  route_next;
  logic [N-1:0]  route_oh;
  logic          err_q;
  flit_type_e    head_type;

  assign push      = in_valid && !full;
  assign head_type = flit_type_e'(head[FW-1:DATA_W]);
  assign route_oh  = N'(xy_route(32'(head[COORD_W-1:0]), 32'(head[2*COORD_W-1:COORD_W]),
                                 32'(MY_X), 32'(MY_Y)));

  yc_noc_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(FW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .wdata(in_flit),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_next = state_q;
    route_next = route_q;
    req        = '0;
    pop        = 1'b0;
    drop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (is_head(head_type)) begin
            route_next = route_oh;
            state_next = S_ROUTED;
          end else begin
            drop = 1'b1;
            pop  = 1'b1;
          end
        end
      end
      S_ROUTED: begin
        // Request is held across the packet but withdrawn while the buffer is starved.
        req = empty ? '0 : route_q;
        if (|(gnt & req)) begin
          pop = 1'b1;
          if (is_tail(head_type)) begin
            route_next = '0;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      route_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      route_q <= route_next;
      err_q   <= drop;
    end
  end

  assign in_ready = !full;
  assign out_flit = head;
  assign err      = err_q;

`ifdef YC_NOC_INPORT_STATS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (state_q == S_ROUTED && |(gnt & req)) cnt_q <= cnt_q + 32'd1;
  end

  assign flit_cnt = cnt_q;
`else
  assign flit_cnt = '0;
`endif

endmodule
